// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out bit serializer with a valid/ready word input and a
// gap-free serial output; the line idles at IDLE_BIT between words.
module piso_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  logic             at_end;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_rest;

  // sreg holds only the bits not yet driven, since the first bit leaves on the load edge
  always_comb begin
    at_end   = (state == SHIFT) && (cnt == CNT_LAST);
    in_ready = (state == IDLE) || at_end;
    accept   = in_valid && in_ready;
    if (MSB_FIRST) begin
      first_bit  = in_data[WIDTH-1];
      load_rest  = in_data << 1;
      next_bit   = sreg[WIDTH-1];
      shift_rest = sreg << 1;
    end else begin
      first_bit  = in_data[0];
      load_rest  = in_data >> 1;
      next_bit   = sreg[0];
      shift_rest = sreg >> 1;
    end
  end

  // Control state, shift register, bit counter and registered serial outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SHIFT;
            sreg      <= load_rest;
            cnt       <= '0;
            ser_out   <= first_bit;
            ser_valid <= 1'b1;
            ser_last  <= 1'b0;
          end else begin
            ser_out   <= IDLE_BIT;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
          end
        end
        SHIFT: begin
          if (at_end && accept) begin
            sreg      <= load_rest;
            cnt       <= '0;
            ser_out   <= first_bit;
            ser_valid <= 1'b1;
            ser_last  <= 1'b0;
          end else if (at_end) begin
            state     <= IDLE;
            cnt       <= '0;
            ser_out   <= IDLE_BIT;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
          end else begin
            sreg      <= shift_rest;
            cnt       <= cnt + CW'(1);
            ser_out   <= next_bit;
            ser_valid <= 1'b1;
            ser_last  <= (cnt == CNT_PRE);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          ser_out   <= IDLE_BIT;
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: directed vector table, corner sequences and
// randomized traffic checked against a bit-queue model of the serial line.
module tb_piso_bit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data;
  logic       v0, v1, v2;
  logic       r0, o0, sv0, sl0, b0;
  logic       r1, o1, sv1, sl1, b1;
  logic       r2, o2, sv2, sl2, b2;

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_data(data), .in_valid(v0), .in_ready(r0),
    .ser_out(o0), .ser_valid(sv0), .ser_last(sl0), .busy(b0));
  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_data(data), .in_valid(v1), .in_ready(r1),
    .ser_out(o1), .ser_valid(sv1), .ser_last(sl1), .busy(b1));
  piso_bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u2 (
    .clk(clk), .rst(rst), .in_data(data[3:0]), .in_valid(v2), .in_ready(r2),
    .ser_out(o2), .ser_valid(sv2), .ser_last(sl2), .busy(b2));

  int checks = 0;
  int failures = 0;

  // Model of u0: queue of line bits still to appear; head is the bit on the line now
  typedef struct packed {logic b; logic l;} ent_t;
  ent_t q[$];
  logic acc;

  typedef struct {logic v; logic [7:0] d; logic eo; logic ev; logic el; logic er;} vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_check();
    logic eo, ev, el;
    ev = (q.size() > 0);
    eo = ev ? q[0].b : 1'b1;
    el = ev ? q[0].l : 1'b0;
    chk("m_out", 32'(o0), 32'(eo));
    chk("m_valid", 32'(sv0), 32'(ev));
    chk("m_last", 32'(sl0), 32'(el));
    chk("m_busy", 32'(b0), 32'(ev));
    chk("m_ready", 32'(r0), 32'(q.size() <= 1));
  endtask

  task automatic tick();
    logic rdy;
    ent_t e;
    rdy = (q.size() <= 1);
    @(posedge clk);
    acc = 1'b0;
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (v0 && rdy) begin
        acc = 1'b1;
        for (int i = 0; i < 8; i++) begin
          e.b = data[7-i];
          e.l = (i == 7);
          q.push_back(e);
        end
      end
    end
    @(negedge clk);
    model_check();
  endtask

  task automatic stream2(input logic [7:0] w1, input logic [7:0] w2);
    logic [15:0] s;
    logic [16:0] rmask;
    logic        vall;
    s = '0; rmask = '0; vall = 1'b1;
    chk("s2_ready_c0", 32'(r0), 32'd1);
    v0 = 1'b1; data = w1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      s = {s[14:0], o0};
      if (!sv0) vall = 1'b0;
      rmask[c] = r0;
      if (c == 1) data = w2;
      if (acc && c > 1) v0 = 1'b0;
    end
    chk("s2_stream", 32'(s), 32'({w1, w2}));
    chk("s2_valid_all", 32'(vall), 32'd1);
    chk("s2_ready_mask", 32'(rmask[15:1]), 32'h0080);
    tick();
    chk("s2_no_dup", 32'(sv0), 32'd0);
    chk("s2_idle", 32'(o0), 32'd1);
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; data = '0; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; acc = 1'b0;
    tick();
    tick();
    chk("rst_out1", 32'(o1), 32'd1);
    chk("rst_valid1", 32'(sv1), 32'd0);
    chk("rst_ready2", 32'(r2), 32'd1);
    chk("rst_busy2", 32'(b2), 32'd0);
    rst = 1'b0;
    tick();

    // Single word 0x66, explicit per-cycle expectations
    for (int i = 0; i < 9; i++) begin
      v0 = tbl[i].v; data = tbl[i].d;
      tick();
      chk("tbl_out", 32'(o0), 32'(tbl[i].eo));
      chk("tbl_valid", 32'(sv0), 32'(tbl[i].ev));
      chk("tbl_last", 32'(sl0), 32'(tbl[i].el));
      chk("tbl_ready", 32'(r0), 32'(tbl[i].er));
    end

    stream2(8'hA5, 8'h3C);
    stream2(8'h12, 8'hFF);

    // LSB-first instance
    chk("lsb_ready", 32'(r1), 32'd1);
    v1 = 1'b1; data = 8'h01;
    tick();
    v1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) tick();
      chk("lsb_out", 32'(o1), 32'(c == 1));
      chk("lsb_last", 32'(sl1), 32'(c == 8));
      chk("lsb_valid", 32'(sv1), 32'd1);
    end
    tick();
    chk("lsb_idle", 32'(o1), 32'd1);
    chk("lsb_idle_valid", 32'(sv1), 32'd0);

    // WIDTH=4 instance, idle -> word -> idle
    v2 = 1'b1; data = 8'h06;
    tick();
    v2 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      chk("w4_out", 32'(o2), 32'((c == 2) || (c == 3)));
      chk("w4_ready", 32'(r2), 32'(c == 4));
      chk("w4_last", 32'(sl2), 32'(c == 4));
    end
    tick();
    chk("w4_idle", 32'(o2), 32'd1);
    chk("w4_idle_valid", 32'(sv2), 32'd0);

    // Reset mid-word with a simultaneous offer, then a fresh word
    v0 = 1'b1; data = 8'hC3;
    tick();
    v0 = 1'b0;
    tick();
    tick();
    rst = 1'b1; v0 = 1'b1; data = 8'h55;
    tick();
    chk("mrst_out", 32'(o0), 32'd1);
    chk("mrst_valid", 32'(sv0), 32'd0);
    chk("mrst_busy", 32'(b0), 32'd0);
    rst = 1'b0; v0 = 1'b0;
    tick();
    chk("mrst_noload", 32'(sv0), 32'd0);
    begin
      logic [7:0] bits;
      bits = '0;
      v0 = 1'b1; data = 8'h0F;
      tick();
      v0 = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        if (c > 1) tick();
        bits = {bits[6:0], o0};
      end
      chk("mrst_fresh", 32'(bits), 32'h0F);
    end

    // Reset while idle with an offer present: nothing is loaded
    tick();
    rst = 1'b1; v0 = 1'b1; data = 8'hAA;
    tick();
    rst = 1'b0; v0 = 1'b0;
    tick();
    chk("irst_noload", 32'(sv0), 32'd0);

    // Randomized traffic; upstream holds an offer until the model says it was taken
    for (int n = 0; n < 800; n++) begin
      if (!v0 || acc) begin
        v0 = ($urandom_range(0, 3) != 0);
        data = 8'($urandom);
      end
      rst = ($urandom_range(0, 79) == 0);
      tick();
    end
    rst = 1'b0; v0 = 1'b0;
    for (int n = 0; n < 12; n++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
